// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, CONV, HOLD} bcd_state_t;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

   // Smallest digit count whose decimal range covers every WIDTH-bit value.
   function automatic int bcd_min_digits(input int width);
      logic [63:0] maxv;
      logic [63:0] p;
      int          d;
      maxv = (64'd1 << width) - 64'd1;
      p    = 64'd1;
      d    = 0;
      for (int i = 0; i < 20; i++) begin
         if (p <= maxv) begin
            p = p * 64'd10;
            d++;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 to any digit of 5 or more
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // A digit is at most 9 here, so the 4-bit sum cannot overflow.
   assign dout = (din >= BCD_ADJ_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - bit-serial binary-to-BCD converter with valid/ready in and out
// Optional leading-zero mask output enabled by defining BCD_BLANK_EN.
module bcd_seq_conv
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy
`ifdef BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int AW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
      $error("bcd_seq_conv: WIDTH out of range 4..16");
   end
   if (DIGITS < bcd_min_digits(WIDTH)) begin : g_bad_digits
      $error("bcd_seq_conv: DIGITS too small for WIDTH");
   end

   bcd_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;
   logic [AW-1:0]    acc;
   logic [AW-1:0]    acc_adj;
   logic [AW-1:0]    acc_step;
   logic             accept;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (acc[4*g +: 4]),
         .dout (acc_adj[4*g +: 4])
      );
   end

   // The bit shifted out of the top digit is always zero, so truncation is safe.
   assign acc_step = (acc_adj << 1) | {{(AW-1){1'b0}}, sh[WIDTH-1]};

   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              hi_zero;

   always_comb begin
      blank_nxt = '0;
      hi_zero   = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         hi_zero      = hi_zero && (acc_step[4*i +: 4] == 4'd0);
         blank_nxt[i] = hi_zero;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sh        <= '0;
         acc       <= '0;
         out_bcd   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef BCD_BLANK_EN
         blank     <= '1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sh    <= in_data;
                  acc   <= '0;
                  cnt   <= CW'(WIDTH);
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               acc <= acc_step;
               sh  <= sh << 1;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  out_bcd   <= acc_step;
`ifdef BCD_BLANK_EN
                  blank     <= blank_nxt;
`endif
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     sh    <= in_data;
                     acc   <= '0;
                     cnt   <= CW'(WIDTH);
                     busy  <= 1'b1;
                     state <= CONV;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb/tb_bcd_seq_conv.sv - scoreboard bench for bcd_seq_conv (WIDTH=8, DIGITS=3)
// Blank checks are compiled in when BCD_BLANK_EN is defined.
module tb_bcd_seq_conv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_bcd;
   logic        busy;
`ifdef BCD_BLANK_EN
   logic [2:0]  blank;
`endif

   int errors = 0;
   int checks = 0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   bcd_seq_conv #(.WIDTH(8), .DIGITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .busy      (busy)
`ifdef BCD_BLANK_EN
      ,
      .blank     (blank)
`endif
   );

   function automatic logic [11:0] model_bcd(input int v);
      logic [3:0] h, t, u;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {h, t, u};
   endfunction

   function automatic logic [2:0] model_blank(input logic [11:0] b);
      logic [2:0] r;
      r[0] = 1'b0;
      r[2] = (b[11:8] == 4'd0);
      r[1] = r[2] && (b[7:4] == 4'd0);
      return r;
   endfunction

   function automatic logic [2:0] cur_blank();
`ifdef BCD_BLANK_EN
      return blank;
`else
      return 3'b000;
`endif
   endfunction

   // Drives one word, waits for the result, then completes the output handshake.
   task automatic run_one(input logic [7:0] v, output int lat, output int busy_n,
                          output int rdy_n, output logic [11:0] bcd,
                          output logic [2:0] blk, output bit to);
      int guard;
      in_data  = v;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      exp_q.push_back(model_bcd(int'(v)));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      lat = 0; busy_n = 0; rdy_n = 0;
      while (!out_valid && lat < 40) begin
         if (busy) busy_n++;
         if (in_ready) rdy_n++;
         @(posedge clk); #1;
         lat++;
      end
      to  = !out_valid;
      bcd = out_bcd;
      blk = cur_blank();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (out_bcd !== 12'h000) begin errors++; $display("FAIL reset_out_bcd: got %h expected 000", out_bcd); end
`ifdef BCD_BLANK_EN
      checks++; if (blank !== 3'b111) begin errors++; $display("FAIL reset_blank: got %b expected 111", blank); end
`endif
   endtask

   task automatic test_single(input string name, input logic [7:0] v);
      int lat, bn, rn;
      logic [11:0] bcd, exp;
      logic [2:0] blk;
      bit to;
      run_one(v, lat, bn, rn, bcd, blk, to);
      exp = exp_q.pop_front();
      checks++; if (to) begin errors++; $display("FAIL %s_timeout: out_valid never rose", name); end
      checks++; if (bcd !== exp) begin errors++; $display("FAIL %s_bcd: got %h expected %h", name, bcd, exp); end
      checks++; if (lat != 8) begin errors++; $display("FAIL %s_latency: got %0d expected 8", name, lat); end
      checks++; if (bn != 8) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 8", name, bn); end
      checks++; if (rn != 0) begin errors++; $display("FAIL %s_in_ready_in_conv: got %0d expected 0", name, rn); end
`ifdef BCD_BLANK_EN
      checks++; if (blk !== model_blank(exp)) begin errors++; $display("FAIL %s_blank: got %b expected %b", name, blk, model_blank(exp)); end
`endif
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL %s_return_idle: got valid=%b ready=%b expected valid=0 ready=1", name, out_valid, in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      logic [11:0] exp;
      int idx, got, cyc, last;
      bit acc_now;
      vals[0] = 8'd3; vals[1] = 8'd99; vals[2] = 8'd200;
      idx = 0; got = 0; cyc = 0; last = 0;
      in_data = vals[0]; in_valid = 1'b1; out_ready = 1'b1;
      while (got < 3 && cyc < 100) begin
         acc_now = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            exp_q.push_back(model_bcd(int'(vals[idx])));
            idx++;
            if (idx < 3) in_data = vals[idx];
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            exp = exp_q.pop_front();
            checks++; if (out_bcd !== exp) begin errors++; $display("FAIL b2b_bcd%0d: got %h expected %h", got, out_bcd, exp); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b expected 1", got, in_ready); end
            if (got > 0) begin
               checks++; if (cyc - last != 9) begin errors++; $display("FAIL b2b_interval%0d: got %0d expected 9", got, cyc - last); end
            end
            last = cyc;
            got++;
         end
      end
      checks++; if (got != 3) begin errors++; $display("FAIL b2b_timeout: got %0d results expected 3", got); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   task automatic test_backpressure();
      int guard;
      logic [11:0] exp;
      in_data = 8'd123; in_valid = 1'b1; out_ready = 1'b0;
      exp_q.push_back(model_bcd(123));
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      exp = exp_q.pop_front();
      checks++; if (!out_valid) begin errors++; $display("FAIL bp_timeout: out_valid never rose"); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1 || out_bcd !== exp || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b bcd=%h ready=%b expected valid=1 bcd=%h ready=0", i, out_valid, out_bcd, in_ready, exp);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follows: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got valid=%b busy=%b ready=%b expected 0 0 1", out_valid, busy, in_ready);
      end
      checks++; if (out_bcd !== exp) begin errors++; $display("FAIL bp_bcd_kept: got %h expected %h", out_bcd, exp); end
   endtask

   task automatic test_reset_mid_conv();
      int seen;
      in_data = 8'd77; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 12'h000) begin
         errors++;
         $display("FAIL rst_mid_outputs: got busy=%b valid=%b ready=%b bcd=%h expected 0 0 1 000", busy, out_valid, in_ready, out_bcd);
      end
`ifdef BCD_BLANK_EN
      checks++; if (blank !== 3'b111) begin errors++; $display("FAIL rst_mid_blank: got %b expected 111", blank); end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_stale_valid: got %0d expected 0", seen); end
      test_single("after_reset_42", 8'd42);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_single("zero", 8'd0);
      test_single("max_255", 8'd255);
      test_single("units_9", 8'd9);
      test_single("tens_10", 8'd10);
      test_back_to_back();
      test_backpressure();
      test_reset_mid_conv();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
